e203_exu_disp_sched: RTL
========================

# e203_exu_disp_sched

Dispatch scheduler between the EXU decoder and the execution units. It holds each decoded instruction at dispatch until it is hazard-free against the outstanding long-pipe instructions (LSU, MULDIV). It allocates and retires entries in a small in-order outstanding-instruction table, and drains that table before fence/CSR/xRET/WFI instructions. It sits after the decoder, which supplies the register indices and enables, and ahead of the ALU/long-pipe issue handshake.

## Interface
- `DEPTH`, default 2: number of outstanding long-pipe entries; power of 2, ≥2.
- `PTR_W`, default 1: log2(DEPTH).
- `RFIDX_W`, default 5: register index width.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  decoded instruction present.
- `i_ready`  out  1  instruction accepted this cycle.
- `i_rs1en`, `i_rs2en`, `i_rdwen`  in  1 each  operand/result enables from the decoder.
- `i_rs1idx`, `i_rs2idx`, `i_rdidx`  in  RFIDX_W each  register indices.
- `i_longp`  in  1  instruction goes to a long pipe (load/store/AMO/muldiv).
- `i_drain`  in  1  instruction requires an empty table (fence, fence.i, CSR, mret, dret, wfi).
- `o_disp_valid`  out  1  issue request to the execution units.
- `o_disp_ready`  in  1  execution units accept the issue.
- `o_disp_ptr`  out  PTR_W  table slot allocated to this issue; valid when `i_longp`.
- `i_ret_ena`  in  1  oldest long-pipe instruction writes back this cycle.
- `o_ret_ptr`  out  PTR_W  slot of the oldest entry.
- `o_ret_rdidx`  out  RFIDX_W  rd of the oldest entry.
- `o_ret_rdwen`  out  1  oldest entry writes rd.
- `o_empty`, `o_full`  out  1 each  table status.
- `o_dep`  out  1  hazard is holding the current instruction.
- `o_draining`  out  1  FSM is in DRAIN.

## Operation
- Table: DEPTH entries of {vld, rdwen, rdidx}. Write pointer and read pointer are each PTR_W+1 bits; the extra MSB is the wrap flag. Empty when the pointers are equal. Full when the LSBs are equal and the wrap flags differ.
- Hazard `o_dep` is asserted when any valid entry has `rdwen`=1 and its `rdidx` matches any of the following:
  - `i_rs1idx` with `i_rs1en` (RAW on rs1);
  - `i_rs2idx` with `i_rs2en` (RAW on rs2);
  - `i_rdidx` with `i_rdwen` (WAW).
  - `o_dep` is gated by `i_valid`.
- Stall sources:
  - `o_dep`;
  - `i_longp` while `o_full`;
  - `i_drain` while not `o_empty`.
- Issue: `o_disp_valid` = `i_valid` & no stall. `i_ready` = `o_disp_valid` & `o_disp_ready`. A fire is `i_ready`=1.
- Allocate on a fire with `i_longp`=1: write {1, `i_rdwen`, `i_rdidx`} at the write pointer, then increment it. `o_disp_ptr` = write pointer LSBs.
- Retire on `i_ret_ena`: clear the entry's vld and increment the read pointer. Retire while empty is ignored; no state change.
- FSM has two states:
  - IDLE → DRAIN when `i_valid` & `i_drain` & not empty.
  - DRAIN → IDLE on the cycle the table is observed empty, or when `i_valid` drops (for example, on a flush).
  - `o_draining` = (state==DRAIN).
  - The FSM is status only. Issue still follows the stall rules, so a drain instruction fires in the same cycle the table becomes empty, with no extra bubble.
- Arithmetic: pointers wrap modulo 2·DEPTH, and the LSBs wrap modulo DEPTH.

## Timing
- Reset (async assert, sync deassert by clocking):
  - both pointers 0, all vld 0, state IDLE;
  - `o_empty`=1, `o_full`=0, `o_draining`=0;
  - `o_ret_*` and `o_disp_ptr` = 0;
  - `o_dep`=0, `o_disp_valid`/`i_ready` follow the inputs.
- Reset mid-operation discards all outstanding entries immediately.
- Hazard check, issue and ready are combinational from the inputs and registered table state: zero-cycle latency.
- Table updates land at the clock edge. An entry allocated at edge N is visible to the hazard check from cycle N+1.
- Simultaneous retire and hazard: the hazard uses pre-edge state, so a dependent instruction stalls one extra cycle. There is no writeback bypass.
- Simultaneous allocate and retire when full: the allocation is stalled (full is pre-edge). The retire proceeds, and the allocation fires the next cycle.
- Simultaneous allocate and retire when partially full: both proceed; occupancy is unchanged.
- Instruction held across stall cycles: inputs must stay stable while `i_valid`=1 and `i_ready`=0.

## Test plan
- Reset, then a non-longp ALU op with `i_valid`=1 and `o_disp_ready`=1 → `i_ready`=1 the same cycle; `o_empty` stays 1.
- Issue a load with rd=x5 (longp), then next cycle an add with rs1=x5 → `o_dep`=1 and `i_ready`=0. Assert `i_ret_ena` → the add fires one cycle after the retire edge.
- With DEPTH=2: issue 2 longp ops → `o_full`=1, and a 3rd longp stalls. Retire and allocate in the same cycle → the allocation is delayed one cycle. Check `o_disp_ptr` sequence 0,1,0 and the wrap-flag flip.
- Table holding 1 entry, present a CSR op (`i_drain`) → `o_draining`=1 next cycle and `i_ready`=0. Retire → the CSR fires in the cycle `o_empty`=1, and the FSM returns to IDLE.
- WAW: outstanding entry rd=x7; instruction with rdwen=1, rd=x7, no rs enables → `o_dep`=1. The same instruction with rd=x0 against entry x7 → no hazard. Retire when empty → pointers unchanged.
- Assert `rst_n`=0 with 2 entries outstanding and the FSM in DRAIN → same-cycle `o_empty`=1, `o_draining`=0, `o_dep`=0.

Source files
------------

// File: rtl/e203_exu_disp_sched.sv
// ---------------------------------------------------------------------------
// e203_exu_disp_sched
//
// Dispatch scheduler between the EXU decoder and the execution units.
// Holds a decoded instruction until it has no RAW/WAW hazard against the
// outstanding long-pipe (LSU/MULDIV) instructions. Keeps those instructions
// in a small in-order table, and drains the table before fence/CSR/xRET/WFI.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_valid / i_ready               decoded instruction in / accepted
//   i_rs1en/i_rs2en/i_rdwen         operand/result enables
//   i_rs1idx/i_rs2idx/i_rdidx       register indices
//   i_longp, i_drain                long-pipe op / needs empty table
//   o_disp_valid / o_disp_ready     issue handshake to execution units
//   o_disp_ptr                      table slot allocated by this issue
//   i_ret_ena                       oldest long-pipe op writes back
//   o_ret_ptr/o_ret_rdidx/o_ret_rdwen  oldest entry info
//   o_empty, o_full                 table status
//   o_dep                           hazard holding current instruction
//   o_draining                      FSM in DRAIN
// ---------------------------------------------------------------------------
module e203_exu_disp_sched #(
  parameter int DEPTH   = 2,
  parameter int PTR_W   = 1,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_rs1en,
  input  logic               i_rs2en,
  input  logic               i_rdwen,
  input  logic [RFIDX_W-1:0] i_rs1idx,
  input  logic [RFIDX_W-1:0] i_rs2idx,
  input  logic [RFIDX_W-1:0] i_rdidx,
  input  logic               i_longp,
  input  logic               i_drain,
  output logic               o_disp_valid,
  input  logic               o_disp_ready,
  output logic [PTR_W-1:0]   o_disp_ptr,
  input  logic               i_ret_ena,
  output logic [PTR_W-1:0]   o_ret_ptr,
  output logic [RFIDX_W-1:0] o_ret_rdidx,
  output logic               o_ret_rdwen,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_dep,
  output logic               o_draining
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry one extra MSB as the wrap flag.
  logic [PTR_W:0]     wr_ptr_r;
  logic [PTR_W:0]     rd_ptr_r;
  logic [DEPTH-1:0]   vld_r;
  logic [DEPTH-1:0]   rdwen_r;
  logic [RFIDX_W-1:0] rdidx_r [DEPTH];
  state_e             state_r;
  state_e             state_nxt_s;

  logic [PTR_W-1:0]   wr_lsb_s;
  logic [PTR_W-1:0]   rd_lsb_s;
  logic [DEPTH-1:0]   hit_s;
  logic               empty_s;
  logic               full_s;
  logic               dep_s;
  logic               stall_s;
  logic               alloc_s;
  logic               retire_s;

  assign wr_lsb_s = wr_ptr_r[PTR_W-1:0];
  assign rd_lsb_s = rd_ptr_r[PTR_W-1:0];
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_lsb_s == rd_lsb_s) && (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]);

  // Per-entry hazard match: outstanding rd against incoming rs1/rs2 (RAW) and rd (WAW).
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s[i] = vld_r[i] & rdwen_r[i] &
                 ((i_rs1en & (rdidx_r[i] == i_rs1idx)) |
                  (i_rs2en & (rdidx_r[i] == i_rs2idx)) |
                  (i_rdwen & (rdidx_r[i] == i_rdidx)));
    end
  end

  assign dep_s    = i_valid & (|hit_s);
  assign stall_s  = dep_s | (i_longp & full_s) | (i_drain & ~empty_s);
  assign alloc_s  = i_ready & i_longp;
  // Retire on an empty table is a no-op.
  assign retire_s = i_ret_ena & ~empty_s;

  assign o_disp_valid = i_valid & ~stall_s;
  assign i_ready      = o_disp_valid & o_disp_ready;
  assign o_disp_ptr   = wr_lsb_s;
  assign o_ret_ptr    = rd_lsb_s;
  assign o_ret_rdidx  = rdidx_r[rd_lsb_s];
  assign o_ret_rdwen  = rdwen_r[rd_lsb_s];
  assign o_empty      = empty_s;
  assign o_full       = full_s;
  assign o_dep        = dep_s;
  assign o_draining   = (state_r == ST_DRAIN);

  // Outstanding table: allocate at write pointer, retire at read pointer.
  // Both may happen in one cycle; they never target the same slot since
  // allocation is blocked when full and retire is ignored when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      vld_r    <= '0;
      rdwen_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdidx_r[i] <= '0;
      end
    end else begin
      if (alloc_s) begin
        vld_r[wr_lsb_s]   <= 1'b1;
        rdwen_r[wr_lsb_s] <= i_rdwen;
        rdidx_r[wr_lsb_s] <= i_rdidx;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end
      if (retire_s) begin
        vld_r[rd_lsb_s] <= 1'b0;
        rd_ptr_r        <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Drain status FSM next-state; it does not gate issue, the stall rules do.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid && i_drain && !empty_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Leave once empty is seen, or if the instruction was flushed.
        if (empty_s || !i_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Drain status FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

endmodule
